data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 89 ++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// CPU data-side responder: word RAM plus a small MMIO page (LED, TIMER, SCRATCH, WRCNT).
// Single-cycle read latency, read-first on every write path.
module data_sram_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [15:0] OFF_LED     = 16'hf000;
  localparam logic [15:0] OFF_TIMER   = 16'hf004;
  localparam logic [15:0] OFF_SCRATCH = 16'hf008;
  localparam logic [15:0] OFF_WRCNT   = 16'hf00c;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       timer;
  logic [31:0]       scratch;
  logic              mmio_sel_c;
  logic [15:0]       offset_c;
  logic [ADDR_W-1:0] index_c;
  logic              ram_we_c;
  logic [31:0]       rd_val_c;

  // Region decode; upper RAM address bits alias onto the array.
  always_comb begin
    mmio_sel_c = (data_sram_addr[31:16] == MMIO_HI);
    offset_c   = data_sram_addr[15:0];
    index_c    = data_sram_addr[ADDR_W+1:2];
    ram_we_c   = data_sram_we && !mmio_sel_c && !reset;
  end

  // Read mux sees pre-edge state, giving read-first behaviour everywhere.
  always_comb begin
    rd_val_c = 32'h0;
    if (mmio_sel_c) begin
      case (offset_c)
        OFF_LED:     rd_val_c = {16'h0, led};
        OFF_TIMER:   rd_val_c = timer;
        OFF_SCRATCH: rd_val_c = scratch;
        OFF_WRCNT:   rd_val_c = wr_count;
        default:     rd_val_c = 32'h0;
      endcase
    end else begin
      rd_val_c = mem[index_c];
    end
  end

  // RAM array carries no reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      mem[index_c] <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sram_rdata <= 32'h0;
      led             <= 16'h0;
      timer           <= 32'h0;
      scratch         <= 32'h0;
      wr_count        <= 32'h0;
    end else begin
      data_sram_rdata <= rd_val_c;
      if (data_sram_we && mmio_sel_c && offset_c == OFF_LED) begin
        led <= data_sram_wdata[15:0];
      end
      if (data_sram_we && mmio_sel_c && offset_c == OFF_TIMER) begin
        timer <= data_sram_wdata;
      end else begin
        timer <= timer + 32'd1;
      end
      if (data_sram_we && mmio_sel_c && offset_c == OFF_SCRATCH) begin
        scratch <= data_sram_wdata;
      end
      if (ram_we_c) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end

endmodule
